// File: rtl/csa_64_pkg.sv
// Shared constants for the 64-bit carry-select adder.
// Datapath: 16 blocks of 4 bits. Used by csa_64_adder and rca_4.
package csa_64_pkg;

    localparam int CSA_WIDTH      = 64;
    localparam int CSA_BLOCK_W    = 4;
    localparam int CSA_NUM_BLOCKS = 16;

endpackage : csa_64_pkg

// File: rtl/csa_64_adder_rca_4.sv
// rca_4: 4-bit ripple-carry adder, the building block of the carry-select chain.
// Purely combinational: {cout,sum} = a + b + cin.
module rca_4
    import csa_64_pkg::*;
(
    input  logic [CSA_BLOCK_W-1:0] a,
    input  logic [CSA_BLOCK_W-1:0] b,
    input  logic                   cin,
    output logic [CSA_BLOCK_W-1:0] sum,
    output logic                   cout
);

    logic ripple_c;

    // Bit-serial ripple: each full adder feeds its carry to the next bit.
    always_comb begin
        ripple_c = cin;
        sum      = '0;
        for (int i = 0; i < CSA_BLOCK_W; i++) begin
            sum[i]   = a[i] ^ b[i] ^ ripple_c;
            ripple_c = (a[i] & b[i]) | (ripple_c & (a[i] ^ b[i]));
        end
        cout = ripple_c;
    end

endmodule : rca_4

// File: rtl/csa_64_adder.sv
// csa_64_adder: registered 64-bit carry-select adder, {cout,sum} = a + b + cin.
// Block 0 is a plain ripple adder fed by cin; blocks 1..15 each precompute the
// result for carry-in 0 and 1 and the previous block's carry picks one.
// Optional macro CSA_64_INPUT_REG_EN adds an input register stage (latency 2);
// without it latency is 1 cycle.
module csa_64_adder
    import csa_64_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CSA_WIDTH-1:0] a,
    input  logic [CSA_WIDTH-1:0] b,
    input  logic                 cin,
    output logic [CSA_WIDTH-1:0] sum,
    output logic                 cout
);

    logic [CSA_WIDTH-1:0] op_a;
    logic [CSA_WIDTH-1:0] op_b;
    logic                 op_cin;

`ifdef CSA_64_INPUT_REG_EN
    logic [CSA_WIDTH-1:0] a_q, a_d;
    logic [CSA_WIDTH-1:0] b_q, b_d;
    logic                 cin_q, cin_d;

    // Input stage next-state: sample the operands every cycle, no stall.
    always_comb begin
        a_d   = a;
        b_d   = b;
        cin_d = cin;
    end

    // Input stage registers, cleared asynchronously while rst is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q   <= '0;
            b_q   <= '0;
            cin_q <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            cin_q <= cin_d;
        end
    end

    assign op_a   = a_q;
    assign op_b   = b_q;
    assign op_cin = cin_q;
`else
    assign op_a   = a;
    assign op_b   = b;
    assign op_cin = cin;
`endif

    // Per-block candidate results; index 0 of the "0" set is the real block 0.
    logic [CSA_BLOCK_W-1:0] blk_sum0  [CSA_NUM_BLOCKS];
    logic                   blk_cout0 [CSA_NUM_BLOCKS];
    logic [CSA_BLOCK_W-1:0] blk_sum1  [1:CSA_NUM_BLOCKS-1];
    logic                   blk_cout1 [1:CSA_NUM_BLOCKS-1];

    rca_4 u_rca_blk0 (
        .a    (op_a[CSA_BLOCK_W-1:0]),
        .b    (op_b[CSA_BLOCK_W-1:0]),
        .cin  (op_cin),
        .sum  (blk_sum0[0]),
        .cout (blk_cout0[0])
    );

    for (genvar gi = 1; gi < CSA_NUM_BLOCKS; gi++) begin : g_blk
        rca_4 u_rca_c0 (
            .a    (op_a[gi*CSA_BLOCK_W +: CSA_BLOCK_W]),
            .b    (op_b[gi*CSA_BLOCK_W +: CSA_BLOCK_W]),
            .cin  (1'b0),
            .sum  (blk_sum0[gi]),
            .cout (blk_cout0[gi])
        );
        rca_4 u_rca_c1 (
            .a    (op_a[gi*CSA_BLOCK_W +: CSA_BLOCK_W]),
            .b    (op_b[gi*CSA_BLOCK_W +: CSA_BLOCK_W]),
            .cin  (1'b1),
            .sum  (blk_sum1[gi]),
            .cout (blk_cout1[gi])
        );
    end

    logic [CSA_WIDTH-1:0]    sum_q, sum_d;
    logic                    cout_q, cout_d;
    logic [CSA_NUM_BLOCKS:1] blk_carry;

    // Carry-select chain: the previous block's carry muxes each block's sum and carry.
    always_comb begin
        sum_d                  = '0;
        blk_carry              = '0;
        sum_d[CSA_BLOCK_W-1:0] = blk_sum0[0];
        blk_carry[1]           = blk_cout0[0];
        for (int i = 1; i < CSA_NUM_BLOCKS; i++) begin
            sum_d[i*CSA_BLOCK_W +: CSA_BLOCK_W] = blk_carry[i] ? blk_sum1[i]  : blk_sum0[i];
            blk_carry[i+1]                      = blk_carry[i] ? blk_cout1[i] : blk_cout0[i];
        end
        cout_d = blk_carry[CSA_NUM_BLOCKS];
    end

    // Output registers, cleared asynchronously while rst is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule : csa_64_adder

// File: tb/tb_csa_64_adder.sv
// Self-checking bench for csa_64_adder: directed cases, async reset, output hold
// and a 10k back-to-back random sweep against a 65-bit arithmetic reference.
// Honours CSA_64_INPUT_REG_EN to select the expected latency.
module tb_csa_64_adder;

`ifdef CSA_64_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int N_RANDOM = 10000;

    logic        clk;
    logic        rst;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [63:0] sum;
    logic        cout;

    int pass_cnt  = 0;
    int total_cnt = 0;

    csa_64_adder dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .sum  (sum),
        .cout (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain 65-bit arithmetic.
    function automatic logic [64:0] ref_add(input logic [63:0] x, input logic [63:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {64'd0, c};
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        a   = 64'h1234_5678_9ABC_DEF0;
        b   = 64'hFFFF_0000_FFFF_0000;
        cin = 1'b1;
        #1;
        total_cnt++;
        if ({cout, sum} !== 65'd0)
            $display("FAIL reset_initial: got cout=%0b sum=%h, want cout=0 sum=0", cout, sum);
        else
            pass_cnt++;
        // Clock edges while held in reset must not load anything.
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if ({cout, sum} !== 65'd0)
            $display("FAIL reset_held: got cout=%0b sum=%h, want cout=0 sum=0", cout, sum);
        else
            pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic do_op(input string name, input logic [63:0] ta, input logic [63:0] tb_,
                         input logic tc, input logic [64:0] expv);
        @(negedge clk);
        a   = ta;
        b   = tb_;
        cin = tc;
        repeat (LAT) @(posedge clk);
        #1;
        total_cnt++;
        if ({cout, sum} !== expv)
            $display("FAIL %s: got cout=%0b sum=%0d, want cout=%0b sum=%0d", name, cout, sum, expv[64], expv[63:0]);
        else
            pass_cnt++;
        $display("op %s: a=%0d b=%0d cin=%0b -> cout=%0b sum=%0d", name, ta, tb_, tc, cout, sum);
    endtask

    task automatic test_directed();
        do_op("basic_add",   64'd2,    64'd5,    1'b0, 65'd7);
        do_op("cin_12",      64'd12,   64'd12,   1'b1, 65'd25);
        do_op("cin_75",      64'd75,   64'd75,   1'b1, 65'd151);
        do_op("bits_11",     64'd1024, 64'd2048, 1'b0, 65'd3072);
        do_op("wide",        64'd9213123, 64'd99812398123, 1'b0, 65'd99821611246);
        do_op("overflow",    64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, {1'b1, 64'd0});
        do_op("blk_carry",   64'h0000_0000_0000_000F, 64'd1, 1'b0, 65'd16);
        do_op("max_max",     64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
              {1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
        do_op("chain_mid",   64'h0000_0000_FFFF_FFFF, 64'd0, 1'b1, 65'h0_0000_0001_0000_0000);
    endtask

    task automatic test_hold();
        logic [64:0] held;
        do_op("hold_setup", 64'd1000, 64'd337, 1'b0, 65'd1337);
        held = 65'd1337;
        // Change inputs between edges: outputs must not move.
        #2;
        a   = 64'd5;
        b   = 64'd5;
        cin = 1'b1;
        #2;
        total_cnt++;
        if ({cout, sum} !== held)
            $display("FAIL hold: got cout=%0b sum=%0d, want cout=%0b sum=%0d", cout, sum, held[64], held[63:0]);
        else
            pass_cnt++;
    endtask

    task automatic test_reset_midstream();
        do_op("pre_reset", 64'd5, 64'd6, 1'b0, 65'd11);
        #2;
        rst = 1'b0;
        #1;
        total_cnt++;
        if ({cout, sum} !== 65'd0)
            $display("FAIL reset_async: got cout=%0b sum=%0d, want cout=0 sum=0", cout, sum);
        else
            pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if ({cout, sum} !== 65'd0)
            $display("FAIL reset_discard: got cout=%0b sum=%0d, want cout=0 sum=0", cout, sum);
        else
            pass_cnt++;
        @(negedge clk);
        a   = 64'd100;
        b   = 64'd23;
        cin = 1'b1;
        rst = 1'b1;
        repeat (LAT) @(posedge clk);
        #1;
        total_cnt++;
        if ({cout, sum} !== 65'd124)
            $display("FAIL reset_release: got cout=%0b sum=%0d, want cout=0 sum=124", cout, sum);
        else
            pass_cnt++;
        $display("op reset_release: a=100 b=23 cin=1 -> cout=%0b sum=%0d", cout, sum);
    endtask

    function automatic logic [63:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 64'hFFFF_FFFF_FFFF_FFFF;
            1:       return 64'd0;
            2:       return {32'd0, $urandom()};
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    task automatic test_back_to_back();
        logic [64:0] exp_q[$];
        logic [64:0] expv;
        int          errs = 0;
        for (int i = 0; i < N_RANDOM + LAT; i++) begin
            @(negedge clk);
            if (exp_q.size() == LAT) begin
                expv = exp_q.pop_front();
                total_cnt++;
                if ({cout, sum} !== expv) begin
                    errs++;
                    $display("FAIL random[%0d]: got cout=%0b sum=%h, want cout=%0b sum=%h",
                             i - LAT, cout, sum, expv[64], expv[63:0]);
                end else begin
                    pass_cnt++;
                end
            end
            if (i < N_RANDOM) begin
                a   = rand_operand();
                b   = rand_operand();
                cin = 1'($urandom_range(0, 1));
                exp_q.push_back(ref_add(a, b, cin));
            end
        end
        $display("op random_sweep: %0d vectors, %0d errors", N_RANDOM, errs);
    endtask

    initial begin
        rst = 1'b0;
        a   = '0;
        b   = '0;
        cin = 1'b0;
        test_reset();
        test_directed();
        test_hold();
        test_reset_midstream();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_csa_64_adder

// File: doc/csa_64_adder.md
CSA_64_ADDER -- requirements
Module: csa_64_adder

Interface
REQ-001 Parameters: none; all widths come from package constants.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 a  input  64  unsigned addend A.
REQ-005 b  input  64  unsigned addend B.
REQ-006 cin  input  1  carry-in.
REQ-007 sum  output  64  registered sum bits [63:0] of a+b+cin.
REQ-008 cout  output  1  registered carry-out, bit 64 of a+b+cin.

Function
REQ-009 The block SHALL compute {cout,sum} = a + b + cin, modulo 2^65, with no truncation of bit 64.
REQ-010 The adder datapath SHALL be a carry-select structure of 16 blocks of 4 bits each.
REQ-011 Block 0 SHALL be a single 4-bit ripple adder fed by cin.
REQ-012 Each block 1..15 SHALL contain two 4-bit ripple adders: one with carry-in 0 and one with carry-in 1.
REQ-013 In each block 1..15, a 2:1 mux SHALL select that block's sum and carry-out, using the carry-out of the previous block as select.
REQ-014 The sum and carry logic SHALL be combinational from a, b and cin to the output register inputs.
REQ-015 sum and cout SHALL be captured on the rising clk edge, giving a latency of exactly 1 cycle from inputs to outputs.
REQ-016 New operands SHALL be accepted every cycle; there is no handshake and no stall.
REQ-017 Outputs SHALL hold their value between edges and SHALL depend only on the inputs sampled at the last edge.
REQ-018 Overflow SHALL appear only as cout=1; sum SHALL wrap modulo 2^64.
REQ-019 X or Z values on inputs are out of scope; behaviour with such inputs is undefined.

Reset
REQ-020 While rst=0, sum SHALL be 64'h0 and cout SHALL be 0, immediately and independent of clk.
REQ-021 Reset asserted mid-stream SHALL discard the in-flight result.
REQ-022 The first valid result after reset release SHALL appear at the first rising edge on which rst=1, using the inputs present at that edge.

Configuration
REQ-023 Macro CSA_64_INPUT_REG_EN, when defined, SHALL add a register stage on a, b and cin ahead of the adder.
REQ-024 With CSA_64_INPUT_REG_EN defined, latency SHALL be 2 cycles.
REQ-025 With CSA_64_INPUT_REG_EN defined, the input registers SHALL reset to 0 asynchronously on rst=0.
REQ-026 Without CSA_64_INPUT_REG_EN, latency SHALL be 1 cycle and no input registers SHALL exist.

Structure
REQ-027 A shared package csa_64_pkg SHALL hold the constants CSA_WIDTH=64, CSA_BLOCK_W=4 and CSA_NUM_BLOCKS=16.
REQ-028 One sub-module, rca_4 (4-bit ripple-carry adder: a, b, cin -> sum, cout), SHALL be instantiated 31 times.
REQ-029 All other logic, including the muxes, the carry chain and the registers, SHALL reside in csa_64_adder.

Verification
REQ-030 Basic add: a=2, b=5, cin=0 -> one cycle later sum=7, cout=0.
REQ-031 Carry-in and 11-bit sums:
- a=12, b=12, cin=1 -> sum=25.
- a=75, b=75, cin=1 -> sum=151.
- a=1024, b=2048, cin=0 -> sum=3072.
- Each of these cases SHALL give cout=0.
REQ-032 Wide operands: a=9213123, b=99812398123, cin=0 -> sum=99821611246, cout=0.
REQ-033 Block-boundary carry and overflow:
- a=64'hFFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> sum=0, cout=1.
- a=64'h0000_0000_0000_000F, b=1, cin=0 -> sum=16.
REQ-034 Reset:
- rst pulled low between clock edges while sum is nonzero -> sum=0 and cout=0 with no clock edge.
- After release, the first edge yields the result of the current operands.
REQ-035 Random sweep: at least 10k back-to-back random {a, b, cin} vectors, one per cycle, each matched against a 65-bit reference sum one cycle later (two cycles later with CSA_64_INPUT_REG_EN).
